crc8_frame_checker: RTL

//  Receive-side CRC-8 checker, the counterpart of the byte-wise CRC-8 generator (poly 1+x^2+x^3+x^5+x^8).

---
 rtl/crc8_frame_checker.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker (poly x^8+x^5+x^3+x^2+1).
// Takes payload bytes followed by one CRC byte (flagged by s_last) and issues
// a one-cycle verdict with the payload length. It also keeps saturating
// frame, CRC-error and length-error counters.
module crc8_frame_checker #(
   parameter logic [7:0] INIT    = 8'hFF,
   parameter int         MAX_LEN = 64,
   parameter int         CNT_W   = 16,
   localparam int        LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic             chk_valid,
   output logic             chk_ok,
   output logic             chk_len_err,
   output logic [LEN_W-1:0] chk_len,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] frm_cnt,
   output logic [CNT_W-1:0] err_crc_cnt,
   output logic [CNT_W-1:0] err_len_cnt
);

   typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN, REPORT} state_t;

   state_t             state_q, state_d;
   logic [7:0]         crc_q, crc_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ready_q, ready_d;
   logic               ok_q, ok_d;
   logic               len_err_q, len_err_d;
   logic [LEN_W-1:0]   chk_len_q, chk_len_d;
   logic [CNT_W-1:0]   frm_cnt_q, err_crc_cnt_q, err_len_cnt_q;
   logic               accept;

   // One byte-wide CRC update, identical to the transmit generator.
   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] t;
      logic [7:0] r;
      t    = c ^ b;
      r[0] = t[0] ^ t[3] ^ t[5];
      r[1] = t[1] ^ t[4] ^ t[6];
      r[2] = t[0] ^ t[2] ^ t[3] ^ t[7];
      r[3] = t[0] ^ t[1] ^ t[4] ^ t[5];
      r[4] = t[1] ^ t[2] ^ t[5] ^ t[6];
      r[5] = t[0] ^ t[2] ^ t[5] ^ t[6] ^ t[7];
      r[6] = t[1] ^ t[3] ^ t[6] ^ t[7];
      r[7] = t[2] ^ t[4] ^ t[7];
      return r;
   endfunction

   assign accept = s_valid & ready_q;

   // Next-state, CRC accumulation and verdict capture.
   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      len_d     = len_q;
      ok_d      = ok_q;
      len_err_d = len_err_q;
      chk_len_d = chk_len_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (s_last) begin
                  // Zero-length payload: the only byte seen is a CRC byte.
                  ok_d      = 1'b0;
                  len_err_d = 1'b1;
                  chk_len_d = '0;
                  state_d   = REPORT;
               end else begin
                  crc_d   = crc_step(crc_q, s_data);
                  len_d   = LEN_W'(1);
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (accept) begin
               if (s_last) begin
                  ok_d      = (s_data == crc_q);
                  len_err_d = 1'b0;
                  chk_len_d = len_q;
                  state_d   = REPORT;
               end else if (len_q == LEN_W'(MAX_LEN)) begin
                  // Over-long frame: stop accumulating, wait for its end.
                  state_d = DRAIN;
               end else begin
                  crc_d = crc_step(crc_q, s_data);
                  len_d = len_q + LEN_W'(1);
               end
            end
         end
         DRAIN: begin
            if (accept && s_last) begin
               ok_d      = 1'b0;
               len_err_d = 1'b1;
               chk_len_d = len_q;
               state_d   = REPORT;
            end
         end
         REPORT: begin
            crc_d   = INIT;
            len_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d != REPORT);
   end

   // Frame state registers; a reset drops any partially received frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         crc_q     <= INIT;
         len_q     <= '0;
         ready_q   <= 1'b0;
         ok_q      <= 1'b0;
         len_err_q <= 1'b0;
         chk_len_q <= '0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         len_q     <= len_d;
         ready_q   <= ready_d;
         ok_q      <= ok_d;
         len_err_q <= len_err_d;
         chk_len_q <= chk_len_d;
      end
   end

   // Saturating status counters, bumped while the verdict is presented; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_cnt_q     <= '0;
         err_crc_cnt_q <= '0;
         err_len_cnt_q <= '0;
      end else if (clr_cnt) begin
         frm_cnt_q     <= '0;
         err_crc_cnt_q <= '0;
         err_len_cnt_q <= '0;
      end else if (state_q == REPORT) begin
         if (frm_cnt_q != '1)
            frm_cnt_q <= frm_cnt_q + CNT_W'(1);
         if (len_err_q) begin
            if (err_len_cnt_q != '1)
               err_len_cnt_q <= err_len_cnt_q + CNT_W'(1);
         end else if (!ok_q) begin
            if (err_crc_cnt_q != '1)
               err_crc_cnt_q <= err_crc_cnt_q + CNT_W'(1);
         end
      end
   end

   assign s_ready     = ready_q;
   assign chk_valid   = (state_q == REPORT);
   assign chk_ok      = ok_q;
   assign chk_len_err = len_err_q;
   assign chk_len     = chk_len_q;
   assign frm_cnt     = frm_cnt_q;
   assign err_crc_cnt = err_crc_cnt_q;
   assign err_len_cnt = err_len_cnt_q;

endmodule
